pad10_1_strip: RTL and testbench
================================

PAD10_1_STRIP -- requirements
Module: pad10_1_strip

Interface
REQ-001 Parameter R_BITS, default 11, width of rate input and length output.
REQ-002 Parameter P_BITS, default 256, width of padded block; P_BITS <= 2**R_BITS - 1.
REQ-003 Port clk  input  1  sole clock, all logic on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request to strip one final padded block.
REQ-006 Port r  input  R_BITS  rate in bits, sampled with start.
REQ-007 Port blk  input  P_BITS  final padded block, bit 0 = first bit, sampled with start.
REQ-008 Port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 Port done  output  1  one-cycle completion pulse.
REQ-010 Port valid  output  1  padding well-formed, held until next accepted start.
REQ-011 Port spill  output  1  leading pad 1 lies in the previous block, held.
REQ-012 Port m_len  output  R_BITS  message bit count in this block, held.
REQ-013 Port err  output  2  00 ok, 01 missing end bit, 10 nonzero tail, 11 bad rate, held.
REQ-014 Port msg  output  P_BITS  block with pad bits cleared (see Configuration).

Function
REQ-015 Pad format: bits [m_len-1:0] message; bit m_len = 1; bits m_len+1..r-2 = 0; bit r-1 = 1; bits r..P_BITS-1 = 0.
REQ-016 FSM states IDLE, CHECK, SCAN, DONE; only IDLE accepts start; start in other states is ignored.
REQ-017 IDLE + start: latch r and blk, clear held results, go to CHECK.
REQ-018 CHECK, single cycle, priority: r<2 or r>P_BITS -> err=11; else blk[r-1]=0 -> err=01; else any blk bit >= r set -> err=10; any error -> DONE; else SCAN with idx=r-2.
REQ-019 SCAN: one bit per cycle, idx decrementing; blk[idx]=1 -> m_len=idx, spill=0, DONE.
REQ-020 SCAN idx=0 with blk[0]=0 -> m_len=0, spill=1, DONE.
REQ-021 DONE: done=1 for exactly one cycle, valid=1 iff err=00, return to IDLE.
REQ-022 Latency from start-sampling edge t: error results done in cycle t+2; scan results done in cycle t+3+(r-2-idx_found).
REQ-023 idx arithmetic in R_BITS unsigned; no wrap below 0 (REQ-020 terminates).
REQ-024 start coincident with done: not accepted (FSM in DONE).

Reset
REQ-025 rst sampled high: state=IDLE; busy, done, valid, spill = 0; m_len=0; err=00; msg=0.
REQ-026 rst overrides start and aborts any CHECK/SCAN; no done pulse for the aborted job.

Configuration
REQ-027 Macro PAD10_1_STRIP_MSG_EN defined: at DONE with valid=1, msg = blk with bits >= m_len cleared (all-zero when spill=1); msg=0 when valid=0.
REQ-028 Macro undefined: msg tied to all-zero, no P_BITS-wide mask register synthesised; all other behaviour identical.

Verification
REQ-029 r=200, blk bits[4:0]=10110, bit5=1, bit199=1 -> done at t+196, m_len=5, valid=1, spill=0, err=00; with macro msg=0x16.
REQ-030 r=200, only bit199 set -> done at t+201, m_len=0, spill=1, valid=1, err=00.
REQ-031 r=200, bit199=0 -> done at t+2, err=01, valid=0.
REQ-032 r=200, bits 199 and 230 set -> done at t+2, err=10, valid=0; r=300 -> err=11.
REQ-033 r=2, blk=0b11 -> done at t+3, m_len=0, spill=0, valid=1.
REQ-034 Start r=200 job, rst at t+50 -> outputs reset, no done; start pulses while busy ignored; next start runs normally.

Source files
------------

// File: rtl/pad10_1_strip.sv
// ---------------------------------------------------------------------------
// pad10_1_strip
//
// Strips pad10*1 padding from the final padded block of a sponge-style hash
// input. A start request latches the rate r and the padded block blk. One
// cycle validates the rate, the closing pad bit and the zero tail above the
// rate. A bit-serial scan then walks down from bit r-2 to find the leading pad
// bit, which marks the message length.
//
// Parameters
//   R_BITS  width of the rate input and the length output (default 11)
//   P_BITS  width of the padded block (default 256), P_BITS <= 2**R_BITS - 1
//
// Ports
//   clk     sole clock, rising edge
//   rst     synchronous active-high reset
//   start   request to strip one block (accepted only when idle)
//   r       rate in bits, sampled with start
//   blk     padded block, bit 0 = first bit, sampled with start
//   busy    high while a job is being checked or scanned
//   done    one-cycle completion pulse
//   valid   padding well-formed (held until the next accepted start)
//   spill   leading pad 1 lies in the previous block (held)
//   m_len   message bit count in this block (held)
//   err     00 ok, 01 missing end bit, 10 nonzero tail, 11 bad rate (held)
//   msg     block with the pad bits cleared
//
// Build option
//   PAD10_1_STRIP_MSG_EN  when defined, msg carries blk with every bit at or
//                         above m_len cleared (all-zero on spill or on error).
//                         When undefined, msg is tied to zero and no
//                         block-wide mask register exists.
// ---------------------------------------------------------------------------
module pad10_1_strip #(
  parameter int R_BITS = 11,
  parameter int P_BITS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [R_BITS-1:0] r,
  input  logic [P_BITS-1:0] blk,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic              spill,
  output logic [R_BITS-1:0] m_len,
  output logic [1:0]        err,
  output logic [P_BITS-1:0] msg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_NO_END   = 2'b01;
  localparam logic [1:0] ERR_TAIL     = 2'b10;
  localparam logic [1:0] ERR_BAD_RATE = 2'b11;

  // Largest legal rate expressed in the rate width, so comparisons stay
  // width-matched.
  localparam logic [R_BITS-1:0] P_MAX  = R_BITS'(P_BITS);
  localparam logic [R_BITS-1:0] R_ONE  = R_BITS'(1);
  localparam logic [R_BITS-1:0] R_TWO  = R_BITS'(2);

  state_t            state_reg;
  logic [R_BITS-1:0] r_reg;
  logic [P_BITS-1:0] blk_reg;
  logic [R_BITS-1:0] idx_reg;

  logic              busy_reg;
  logic              done_reg;
  logic              valid_reg;
  logic              spill_reg;
  logic [R_BITS-1:0] m_len_reg;
  logic [1:0]        err_reg;

  // -------------------------------------------------------------------------
  // CHECK-stage qualifiers, all derived from the latched job.
  // -------------------------------------------------------------------------
  logic              rate_bad;
  logic [P_BITS-1:0] end_shift;
  logic              end_bit;
  logic [P_BITS-1:0] tail_bits;
  logic              tail_set;

  assign rate_bad = (r_reg < R_TWO) || (r_reg > P_MAX);

  // Closing pad bit blk[r-1]. Shifting instead of indexing keeps the rate
  // width independent of the block width. The value is meaningless when the
  // rate is bad, but the bad-rate test takes priority.
  assign end_shift = blk_reg >> (r_reg - R_ONE);
  assign end_bit   = end_shift[0];

  // Every bit at or above the rate must be zero.
  generate
    for (genvar gi = 0; gi < P_BITS; gi++) begin : g_tail
      assign tail_bits[gi] = blk_reg[gi] & (R_BITS'(gi) >= r_reg);
    end
  endgenerate

  assign tail_set = |tail_bits;

  // -------------------------------------------------------------------------
  // SCAN-stage bit select: the block bit at the current scan index.
  // -------------------------------------------------------------------------
  logic [P_BITS-1:0] idx_shift;
  logic              idx_bit;
  logic              idx_zero;

  assign idx_shift = blk_reg >> idx_reg;
  assign idx_bit   = idx_shift[0];
  assign idx_zero  = (idx_reg == '0);

`ifdef PAD10_1_STRIP_MSG_EN
  // Mask of the message bits below the current scan index. It is only
  // sampled in the cycle the leading pad bit is found, when idx_reg is the
  // message length.
  logic [P_BITS-1:0] low_mask;
  logic [P_BITS-1:0] msg_reg;

  generate
    for (genvar gi = 0; gi < P_BITS; gi++) begin : g_low_mask
      assign low_mask[gi] = (R_BITS'(gi) < idx_reg);
    end
  endgenerate
`endif

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs. Results are written on the edge
  // that enters DONE, so they are visible in the same cycle as the done
  // pulse and are held afterwards.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      blk_reg   <= '0;
      idx_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      valid_reg <= 1'b0;
      spill_reg <= 1'b0;
      m_len_reg <= '0;
      err_reg   <= ERR_OK;
`ifdef PAD10_1_STRIP_MSG_EN
      msg_reg   <= '0;
`endif
    end else begin
      // done is a single-cycle pulse; only the transition into DONE sets it.
      done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            r_reg     <= r;
            blk_reg   <= blk;
            busy_reg  <= 1'b1;
            valid_reg <= 1'b0;
            spill_reg <= 1'b0;
            m_len_reg <= '0;
            err_reg   <= ERR_OK;
`ifdef PAD10_1_STRIP_MSG_EN
            msg_reg   <= '0;
`endif
            state_reg <= CHECK;
          end
        end

        CHECK: begin
          if (rate_bad) begin
            err_reg   <= ERR_BAD_RATE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else if (!end_bit) begin
            err_reg   <= ERR_NO_END;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else if (tail_set) begin
            err_reg   <= ERR_TAIL;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            // The leading pad bit sits at or below r-2.
            idx_reg   <= r_reg - R_TWO;
            state_reg <= SCAN;
          end
        end

        SCAN: begin
          if (idx_bit) begin
            // Highest set bit below the closing pad bit is the leading pad
            // bit; everything beneath it is message.
            m_len_reg <= idx_reg;
            spill_reg <= 1'b0;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
`ifdef PAD10_1_STRIP_MSG_EN
            msg_reg   <= blk_reg & low_mask;
`endif
            state_reg <= DONE;
          end else if (idx_zero) begin
            // No leading pad bit in this block: it was the last bit of the
            // previous block, and this block carries no message bits. The
            // scan stops here rather than wrapping the index.
            m_len_reg <= '0;
            spill_reg <= 1'b1;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg - R_ONE;
          end
        end

        DONE: begin
          // start is deliberately not examined here.
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign valid = valid_reg;
  assign spill = spill_reg;
  assign m_len = m_len_reg;
  assign err   = err_reg;

`ifdef PAD10_1_STRIP_MSG_EN
  assign msg = msg_reg;
`else
  assign msg = '0;
`endif

endmodule

// File: tb/tb_pad10_1_strip.sv
// ---------------------------------------------------------------------------
// Self-checking bench for pad10_1_strip. Directed jobs cover the worked
// examples, a reset abort and ignored start pulses; a batch of random jobs
// (well-formed, spill, missing end bit, nonzero tail, bad rate) follows.
// Expected results come from a reference function that applies the pad
// format rules directly to the block.
// ---------------------------------------------------------------------------
module tb_pad10_1_strip;

  localparam int RB = 11;
  localparam int PB = 256;
  localparam int TIMEOUT = 600;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RB-1:0] r;
  logic [PB-1:0] blk;
  logic          busy;
  logic          done;
  logic          valid;
  logic          spill;
  logic [RB-1:0] m_len;
  logic [1:0]    err;
  logic [PB-1:0] msg;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  pad10_1_strip #(.R_BITS(RB), .P_BITS(PB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .r     (r),
    .blk   (blk),
    .busy  (busy),
    .done  (done),
    .valid (valid),
    .spill (spill),
    .m_len (m_len),
    .err   (err),
    .msg   (msg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the pad10*1 rules. Latency is counted in clock edges
  // from the edge that samples start to the edge after which done is seen.
  function automatic void model(input int rr, input logic [PB-1:0] b,
                                output logic [1:0] e, output int ml,
                                output logic sp, output logic vl,
                                output int lat, output logic [PB-1:0] m);
    int lead;
    e = 2'b00; ml = 0; sp = 1'b0; vl = 1'b0; lat = 2; m = '0;
    if (rr < 2 || rr > PB) e = 2'b11;
    else if (!b[rr-1]) e = 2'b01;
    else begin
      for (int i = rr; i < PB; i++) if (b[i]) e = 2'b10;
    end
    if (e == 2'b00) begin
      lead = -1;
      for (int i = rr - 2; i >= 0; i--) begin
        if (b[i]) begin
          lead = i;
          break;
        end
      end
      vl = 1'b1;
      if (lead < 0) begin
        sp  = 1'b1;
        ml  = 0;
        lat = 3 + (rr - 2);
      end else begin
        ml  = lead;
        lat = 3 + (rr - 2 - lead);
`ifdef PAD10_1_STRIP_MSG_EN
        for (int i = 0; i < lead; i++) m[i] = b[i];
`endif
      end
    end
  endfunction

  task automatic run_job(input string name, input int rr, input logic [PB-1:0] b,
                         input bit noise);
    logic [1:0]    e_err;
    int            e_ml;
    logic          e_sp;
    logic          e_vl;
    int            e_lat;
    logic [PB-1:0] e_msg;
    int            n;
    bit            got;
    model(rr, b, e_err, e_ml, e_sp, e_vl, e_lat, e_msg);
    @(negedge clk);
    start = 1'b1;
    r     = RB'(rr);
    blk   = b;
    @(posedge clk);
    n   = 0;
    got = 0;
    while (n < TIMEOUT && !got) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 1) chk({name, ".busy"}, PB'(busy), PB'(1));
      if (done) got = 1;
      else if (noise) begin
        // Start pulses while busy must be ignored.
        start = 1'($urandom);
        r     = RB'($urandom_range(0, 2047));
        blk   = {8{$urandom}};
      end
    end
    start = 1'b0;
    chk({name, ".done_seen"}, PB'(got), PB'(1));
    chk({name, ".latency"}, PB'(n), PB'(e_lat));
    chk({name, ".err"}, PB'(err), PB'(e_err));
    chk({name, ".m_len"}, PB'(m_len), PB'(e_ml));
    chk({name, ".spill"}, PB'(spill), PB'(e_sp));
    chk({name, ".valid"}, PB'(valid), PB'(e_vl));
    chk({name, ".msg"}, msg, e_msg);
    @(negedge clk);
    chk({name, ".done_pulse"}, PB'(done), PB'(0));
    chk({name, ".valid_held"}, PB'(valid), PB'(e_vl));
    $display("job %s: r=%0d err=%0d m_len=%0d spill=%0d valid=%0d latency=%0d", name, rr,
             err, m_len, spill, valid, n);
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".busy"}, PB'(busy), PB'(0));
    chk({name, ".done"}, PB'(done), PB'(0));
    chk({name, ".valid"}, PB'(valid), PB'(0));
    chk({name, ".spill"}, PB'(spill), PB'(0));
    chk({name, ".m_len"}, PB'(m_len), PB'(0));
    chk({name, ".err"}, PB'(err), PB'(0));
    chk({name, ".msg"}, msg, PB'(0));
  endtask

  initial begin
    logic [PB-1:0] b;
    int            rr;
    int            m;
    int            cat;
    bit            done_seen;

    rst   = 1'b1;
    start = 1'b0;
    r     = '0;
    blk   = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    // Message 10110 then leading pad bit 5, closing bit 199.
    b = '0; b[4:0] = 5'b10110; b[5] = 1'b1; b[199] = 1'b1;
    run_job("msg5", 200, b, 0);

    b = '0; b[199] = 1'b1;
    run_job("spill", 200, b, 0);

    b = '0; b[5] = 1'b1;
    run_job("no_end", 200, b, 0);

    b = '0; b[199] = 1'b1; b[230] = 1'b1;
    run_job("tail", 200, b, 0);
    run_job("bad_rate", 300, b, 0);

    b = '0; b[1:0] = 2'b11;
    run_job("r2", 2, b, 0);

    // Abort a long job with reset; start held high during reset.
    b = '0; b[199] = 1'b1;
    @(negedge clk);
    start = 1'b1; r = RB'(200); blk = b;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    repeat (49) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    chk("abort.busy_before", PB'(busy), PB'(1));
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk_idle("abort");
    @(negedge clk);
    if (done) done_seen = 1;
    chk("abort.no_done", PB'(done_seen), PB'(0));
    chk("abort.still_idle", PB'(busy), PB'(0));

    // Next job after abort, with spurious starts while busy.
    b = '0; b[6:0] = 7'b1011001; b[40] = 1'b1; b[99] = 1'b1;
    run_job("after_abort", 100, b, 1);

    for (int k = 0; k < 24; k++) begin
      cat = $urandom_range(0, 4);
      b   = '0;
      rr  = $urandom_range(2, PB);
      case (cat)
        0: begin
          m = $urandom_range(0, rr - 2);
          for (int i = 0; i < m; i++) b[i] = 1'($urandom);
          b[m] = 1'b1;
          b[rr-1] = 1'b1;
        end
        1: b[rr-1] = 1'b1;
        2: begin
          for (int i = 0; i < rr - 1; i++) b[i] = 1'($urandom);
        end
        3: begin
          rr = $urandom_range(2, PB - 1);
          m  = $urandom_range(0, rr - 2);
          for (int i = 0; i < m; i++) b[i] = 1'($urandom);
          b[m] = 1'b1;
          b[rr-1] = 1'b1;
          b[$urandom_range(rr, PB - 1)] = 1'b1;
        end
        default: begin
          rr = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1) : $urandom_range(PB + 1, 2047);
          b  = {8{$urandom}};
        end
      endcase
      run_job($sformatf("rand%0d_c%0d", k, cat), rr, b, bit'(k % 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
